// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle unsigned ALU: add/sub, shift-add multiply, restoring divide
module seq_alu #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] rem,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  // Iterations remaining after the current one; the final iteration runs at cnt == 0.
  logic [CW-1:0] cnt;

  // Multiplicand during MUL, divisor during DIV.
  logic [WIDTH-1:0] opnd_q;

  // MUL: {partial product high half, remaining multiplier bits}.
  // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [2*WIDTH-1:0] acc;

  logic accept;

  logic [WIDTH:0]       add_ext;
  logic [WIDTH-1:0]     sub_res;
  logic                 sub_borrow;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_next;

  // Single-cycle operations, evaluated on the live operands at accept time.
  assign add_ext    = {1'b0, A} + {1'b0, B};
  assign sub_res    = A - B;
  assign sub_borrow = (A < B);

  // One shift-add step: conditionally add the multiplicand into the high half
  // (keeping the carry), then shift the whole accumulator right by one.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, and record the quotient bit.
  // The partial remainder is always below the divisor, so the shifted value is
  // below twice the divisor and the difference fits in WIDTH bits.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

  assign accept = start && ready;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, handshake and result-strobe decode.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    res_valid  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        ready      = 1'b1;
        res_valid  = (state == S_DONE);
        state_next = S_IDLE;
        if (start) begin
          case (op)
            OP_ADD:  state_next = S_DONE;
            OP_SUB:  state_next = S_DONE;
            OP_MUL:  state_next = S_MUL;
            OP_DIV:  state_next = (B == '0) ? S_DONE : S_DIV;
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cnt == '0) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opnd_q <= '0;
      acc    <= '0;
      res    <= '0;
      rem    <= '0;
      ovf    <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            cnt <= CW'(WIDTH - 1);
            case (op)
              OP_ADD: begin
                res <= add_ext[WIDTH-1:0];
                rem <= '0;
                ovf <= add_ext[WIDTH];
                dbz <= 1'b0;
              end
              OP_SUB: begin
                res <= sub_res;
                rem <= '0;
                ovf <= sub_borrow;
                dbz <= 1'b0;
              end
              OP_MUL: begin
                opnd_q <= A;
                acc    <= {{WIDTH{1'b0}}, B};
              end
              OP_DIV: begin
                if (B == '0) begin
                  res <= '1;
                  rem <= A;
                  ovf <= 1'b0;
                  dbz <= 1'b1;
                end else begin
                  opnd_q <= B;
                  acc    <= {{WIDTH{1'b0}}, A};
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= mul_next;
          if (cnt == '0) begin
            res <= mul_next[WIDTH-1:0];
            rem <= '0;
            ovf <= |mul_next[2*WIDTH-1:WIDTH];
            dbz <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DIV: begin
          acc <= div_next;
          if (cnt == '0) begin
            res <= div_next[WIDTH-1:0];
            rem <= div_next[2*WIDTH-1:WIDTH];
            ovf <= 1'b0;
            dbz <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu at WIDTH 20 and WIDTH 8
module tb_seq_alu;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic [31:0] ovf;
    logic [31:0] dbz;
    int          due;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  item_t q20[$];
  item_t q8[$];

  logic        s20 = 1'b0;
  logic [19:0] a20 = '0;
  logic [19:0] b20 = '0;
  logic [1:0]  op20 = '0;
  logic        ready20, valid20, ovf20, dbz20;
  logic [19:0] res20, rem20;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [1:0]  op8 = '0;
  logic        ready8, valid8, ovf8, dbz8;
  logic [7:0]  res8, rem8;

  seq_alu u20 (
    .clk(clk), .rst(rst), .start(s20), .A(a20), .B(b20), .op(op20),
    .ready(ready20), .res_valid(valid20), .res(res20), .rem(rem20),
    .ovf(ovf20), .dbz(dbz20)
  );

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .A(a8), .B(b8), .op(op8),
    .ready(ready8), .res_valid(valid8), .res(res8), .rem(rem8),
    .ovf(ovf8), .dbz(dbz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model in wide integer arithmetic; due = cycle count when res_valid must show.
  function automatic item_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] o, input int w, input int now);
    longint unsigned mask, x, y, p;
    item_t it;
    mask = (64'd1 << w) - 64'd1;
    x = 64'(a);
    y = 64'(b);
    it.res = '0;
    it.rem = '0;
    it.ovf = '0;
    it.dbz = '0;
    it.due = now + 1;
    case (o)
      2'b00: begin
        p = x + y;
        it.res = 32'(p & mask);
        it.ovf = 32'((p >> w) != 0);
      end
      2'b01: begin
        it.res = 32'((x - y) & mask);
        it.ovf = 32'(x < y);
      end
      2'b10: begin
        p = x * y;
        it.res = 32'(p & mask);
        it.ovf = 32'((p >> w) != 0);
        it.due = now + w + 1;
      end
      default: begin
        if (y == 0) begin
          it.res = 32'(mask);
          it.rem = 32'(x);
          it.dbz = 32'd1;
        end else begin
          it.res = 32'(x / y);
          it.rem = 32'(x % y);
          it.due = now + w + 1;
        end
      end
    endcase
    return it;
  endfunction

  // Result monitors: every res_valid pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    item_t it;
    #1;
    if (valid20) begin
      chk("w20_result_expected", 32'(q20.size() > 0), 32'd1);
      if (q20.size() > 0) begin
        it = q20.pop_front();
        chk("w20_res", 32'(res20), it.res);
        chk("w20_rem", 32'(rem20), it.rem);
        chk("w20_ovf", 32'(ovf20), it.ovf);
        chk("w20_dbz", 32'(dbz20), it.dbz);
        chk("w20_latency_cycle", 32'(cyc), 32'(it.due));
      end
    end
    if (valid8) begin
      chk("w8_result_expected", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) begin
        it = q8.pop_front();
        chk("w8_res", 32'(res8), it.res);
        chk("w8_rem", 32'(rem8), it.rem);
        chk("w8_ovf", 32'(ovf8), it.ovf);
        chk("w8_dbz", 32'(dbz8), it.dbz);
        chk("w8_latency_cycle", 32'(cyc), 32'(it.due));
      end
    end
  end

  // Drive one start cycle (caller is at a negedge); track=1 registers an expected result.
  task automatic go20(input logic [19:0] a, input logic [19:0] b, input logic [1:0] o, input bit track);
    a20 = a; b20 = b; op20 = o; s20 = 1'b1;
    if (track) q20.push_back(model(32'(a), 32'(b), o, 20, cyc));
    @(negedge clk);
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o, input bit track);
    a8 = a; b8 = b; op8 = o; s8 = 1'b1;
    if (track) q8.push_back(model(32'(a), 32'(b), o, 8, cyc));
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && (q20.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    chk(tag, 32'(q20.size() + q8.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_ready", 32'(ready20), 32'd1);
    chk("reset_valid", 32'(valid20), 32'd0);
    chk("reset_res", 32'(res20), 32'd0);
    chk("reset_rem", 32'(rem20), 32'd0);
    chk("reset_ovf", 32'(ovf20), 32'd0);
    chk("reset_dbz", 32'(dbz20), 32'd0);
    chk("reset_ready_w8", 32'(ready8), 32'd1);

    // Back-to-back ADD, SUB, SUB with borrow.
    go20(20'd123, 20'd321, 2'b00, 1'b1);
    go20(20'd28, 20'd6, 2'b01, 1'b1);
    go20(20'd6, 20'd28, 2'b01, 1'b1);
    s20 = 1'b0;
    drain("drain_addsub", 5);

    // MUL with busy window check.
    go20(20'd36, 20'd17, 2'b10, 1'b1);
    s20 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("mul_busy_ready", 32'(ready20), 32'd0);
      @(negedge clk);
    end
    chk("mul_done_ready", 32'(ready20), 32'd1);
    drain("drain_mul", 5);

    go20(20'h80000, 20'd2, 2'b10, 1'b1);
    s20 = 1'b0;
    drain("drain_mul_ovf", 30);

    go20(20'd12, 20'd4, 2'b11, 1'b1);
    s20 = 1'b0;
    drain("drain_div12", 30);
    go20(20'd100, 20'd7, 2'b11, 1'b1);
    s20 = 1'b0;
    drain("drain_div100", 30);
    go20(20'd5, 20'd0, 2'b11, 1'b1);
    s20 = 1'b0;
    drain("drain_dbz", 5);

    // Busy rejection: ADD pulsed mid-MUL must leave no trace.
    go20(20'd36, 20'd17, 2'b10, 1'b1);
    s20 = 1'b0;
    repeat (3) @(negedge clk);
    go20(20'd1, 20'd1, 2'b00, 1'b0);
    s20 = 1'b0;
    chk("busy_ready", 32'(ready20), 32'd0);
    drain("drain_busy", 30);
    repeat (3) @(negedge clk);
    chk("busy_no_extra", 32'(valid20), 32'd0);

    // Reset in the middle of a divide.
    go20(20'd100, 20'd7, 2'b11, 1'b0);
    s20 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(ready20), 32'd1);
    chk("midrst_valid", 32'(valid20), 32'd0);
    chk("midrst_res", 32'(res20), 32'd0);
    chk("midrst_rem", 32'(rem20), 32'd0);
    for (int i = 0; i < 25; i++) begin
      chk("midrst_no_valid", 32'(valid20), 32'd0);
      @(negedge clk);
    end
    go20(20'd123, 20'd321, 2'b00, 1'b1);
    s20 = 1'b0;
    drain("drain_after_rst", 5);

    // Reset and start together: reset wins.
    rst = 1'b1;
    go20(20'd1, 20'd1, 2'b00, 1'b0);
    rst = 1'b0;
    s20 = 1'b0;
    chk("rst_start_valid", 32'(valid20), 32'd0);
    chk("rst_start_res", 32'(res20), 32'd0);
    @(negedge clk);
    chk("rst_start_valid_late", 32'(valid20), 32'd0);

    // ADD wrap at the top of the range.
    go20(20'hFFFFF, 20'd1, 2'b00, 1'b1);
    s20 = 1'b0;
    drain("drain_wrap", 5);

    // Narrow instance: MUL and DIV at WIDTH 8.
    go8(8'd15, 8'd17, 2'b10, 1'b1);
    s8 = 1'b0;
    drain("drain_w8_mul", 20);
    go8(8'd200, 8'd9, 2'b11, 1'b1);
    s8 = 1'b0;
    drain("drain_w8_div", 20);
    go8(8'd16, 8'd16, 2'b10, 1'b1);
    s8 = 1'b0;
    drain("drain_w8_mul_ovf", 20);
    go8(8'd250, 8'd10, 2'b00, 1'b1);
    s8 = 1'b0;
    drain("drain_w8_add", 5);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
